// File: rtl/mio_pkg.sv
// Shared definitions for the MIO bus blitter: FSM states, region nibbles and colour key.
package mio_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ,
        S_RD,
        S_WR,
        S_NEXT,
        S_DONE
    } blit_state_e;

    localparam logic [3:0] REGION_VRAM = 4'hC;
    localparam logic [3:0] REGION_BG   = 4'hB;
    localparam logic [3:0] REGION_CHAR = 4'hA;
    localparam logic [3:0] REGION_CI   = 4'h9;
    localparam logic [3:0] REGION_WALL = 4'h8;

    localparam logic [11:0] TRANSP_DEFAULT = 12'hF0F;

endpackage

// File: rtl/mio_blit_addr_gen.sv
// Tile walk counters: x/y/idx plus the wrapped VRAM pixel address of the current pixel.
module mio_blit_addr_gen #(
    parameter int TILE_W = 32,
    parameter int TILE_H = 32,
    parameter int STRIDE = 512
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_clear,
    input  logic        i_advance,
    input  logic [17:0] i_dst_off,
    output logic [17:0] o_dst_addr,
    output logic [9:0]  o_idx,
    output logic        o_last
);

    localparam int XW = (TILE_W > 1) ? $clog2(TILE_W) : 1;
    localparam int YW = (TILE_H > 1) ? $clog2(TILE_H) : 1;
    localparam logic [XW-1:0] X_LAST   = XW'(TILE_W - 1);
    localparam logic [YW-1:0] Y_LAST   = YW'(TILE_H - 1);
    localparam logic [17:0]   STRIDE18 = 18'(STRIDE);

    logic [XW-1:0] r_x;
    logic [YW-1:0] r_y;
    logic [9:0]    r_idx;
    logic [17:0]   r_row_base;

    // r_row_base tracks dst_off + y*STRIDE (mod 2^18) by adding one stride per row.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_x        <= '0;
            r_y        <= '0;
            r_idx      <= '0;
            r_row_base <= '0;
        end else if (i_clear) begin
            r_x        <= '0;
            r_y        <= '0;
            r_idx      <= '0;
            r_row_base <= i_dst_off;
        end else if (i_advance) begin
            r_idx <= r_idx + 10'd1;
            if (r_x == X_LAST) begin
                r_x        <= '0;
                r_y        <= r_y + YW'(1);
                r_row_base <= r_row_base + STRIDE18;
            end else begin
                r_x <= r_x + XW'(1);
            end
        end
    end

    assign o_dst_addr = r_row_base + 18'(r_x);
    assign o_idx      = r_idx;
    assign o_last     = (r_x == X_LAST) && (r_y == Y_LAST);

endmodule

// File: rtl/mio_blit_master.sv
// MIO bus master that copies one sprite tile from ROM into VRAM, skipping colour-keyed pixels.
module mio_blit_master
    import mio_pkg::*;
#(
    parameter int          TILE_W = 32,
    parameter int          TILE_H = 32,
    parameter int          STRIDE = 512,
    parameter int          RD_LAT = 2,
    parameter logic [11:0] TRANSP = TRANSP_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [31:0] src_base,
    input  logic [17:0] dst_off,
    output logic        busy,
    output logic        done,
    output logic        bus_req,
    input  logic        bus_gnt,
    output logic [31:0] addr_bus,
    output logic        mem_w,
    output logic [31:0] data2bus,
    input  logic [31:0] data4bus,
    output blit_state_e dbg_state
);

    localparam int LAT_W = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;
    localparam logic [LAT_W-1:0] LAT_LAST = LAT_W'(RD_LAT - 1);

    blit_state_e      r_state;
    blit_state_e      w_next;
    logic [31:0]      r_src;
    logic [11:0]      r_pix;
    logic [LAT_W-1:0] r_lat_cnt;

    logic        w_clear;
    logic        w_advance;
    logic        w_rd_last;
    logic        w_rd_cap;
    logic        w_last;
    logic        w_active;
    logic [17:0] w_dst;
    logic [9:0]  w_idx;
    logic        w_unused_hi;

    mio_blit_addr_gen #(
        .TILE_W (TILE_W),
        .TILE_H (TILE_H),
        .STRIDE (STRIDE)
    ) u_addr_gen (
        .clk        (clk),
        .rst        (rst),
        .i_clear    (w_clear),
        .i_advance  (w_advance),
        .i_dst_off  (dst_off),
        .o_dst_addr (w_dst),
        .o_idx      (w_idx),
        .o_last     (w_last)
    );

    assign w_rd_last   = (r_lat_cnt == LAT_LAST);
    assign w_rd_cap    = (r_state == S_RD) && bus_gnt && w_rd_last;
    assign w_unused_hi = ^data4bus[31:12];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state   <= S_IDLE;
            r_src     <= '0;
            r_pix     <= '0;
            r_lat_cnt <= '0;
        end else begin
            r_state <= w_next;
            if (w_clear) begin
                r_src <= src_base;
            end
            if (w_rd_cap) begin
                r_pix <= data4bus[11:0];
            end
            // Latency count restarts on every entry to RD, so a retried read waits the full RD_LAT.
            if ((r_state == S_RD) && bus_gnt && !w_rd_last) begin
                r_lat_cnt <= r_lat_cnt + LAT_W'(1);
            end else begin
                r_lat_cnt <= '0;
            end
        end
    end

    always_comb begin
        w_next    = r_state;
        w_clear   = 1'b0;
        w_advance = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_clear = 1'b1;
                    w_next  = S_REQ;
                end
            end
            S_REQ: begin
                if (bus_gnt) begin
                    w_next = S_RD;
                end
            end
            S_RD: begin
                if (!bus_gnt) begin
                    w_next = S_REQ;
                end else if (w_rd_last) begin
                    w_next = (data4bus[11:0] == TRANSP) ? S_NEXT : S_WR;
                end
            end
            S_WR: begin
                w_next = bus_gnt ? S_NEXT : S_REQ;
            end
            S_NEXT: begin
                w_advance = 1'b1;
                w_next    = w_last ? S_DONE : S_RD;
            end
            S_DONE: begin
                w_next = S_IDLE;
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    // Bus outputs are gated by bus_gnt combinationally so a grant loss kills the cycle at once.
    assign w_active = (r_state == S_REQ) || (r_state == S_RD) ||
                      (r_state == S_WR)  || (r_state == S_NEXT);
    assign busy     = w_active;
    assign bus_req  = w_active;
    assign done     = (r_state == S_DONE);
    assign mem_w    = bus_gnt && (r_state == S_WR);
    assign data2bus = mem_w ? {20'b0, r_pix} : 32'b0;
    assign addr_bus = !bus_gnt            ? 32'b0 :
                      (r_state == S_WR)   ? {REGION_VRAM, 10'b0, w_dst} :
                      (r_state == S_RD)   ? (r_src + {22'b0, w_idx}) : 32'b0;
    assign dbg_state = r_state;

endmodule

// File: tb/tb_mio_blit_master.sv
// Directed bench for mio_blit_master: opaque, keyed, wrapped, grant-loss, busy-start and reset-abort tiles.
module tb_mio_blit_master;
    import mio_pkg::*;

    logic        clk      = 1'b0;
    logic        rst      = 1'b0;
    logic        start    = 1'b0;
    logic [31:0] src_base = '0;
    logic [17:0] dst_off  = '0;
    logic        bus_gnt  = 1'b1;
    logic [31:0] data4bus = '0;
    logic        busy, done, bus_req, mem_w;
    logic [31:0] addr_bus, data2bus;
    blit_state_e dbg_state;

    int tests = 0;
    int fails = 0;

    mio_blit_master dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .src_base  (src_base),
        .dst_off   (dst_off),
        .busy      (busy),
        .done      (done),
        .bus_req   (bus_req),
        .bus_gnt   (bus_gnt),
        .addr_bus  (addr_bus),
        .mem_w     (mem_w),
        .data2bus  (data2bus),
        .data4bus  (data4bus),
        .dbg_state (dbg_state)
    );

    always #5 clk = ~clk;

    // Sprite ROM: one registered stage, pixel = idx, optionally keyed on odd idx.
    bit rom_odd = 1'b0;
    function automatic logic [31:0] rom_word(input logic [31:0] a);
        if (rom_odd && a[0]) return 32'h0000_0F0F;
        return {22'b0, a[9:0]};
    endfunction
    always @(posedge clk) data4bus <= rom_word(addr_bus);

    logic [31:0] wr_a[$], wr_d[$];
    logic [31:0] exp_q[$], exp_d[$];
    int t_rd, t_done, done_cnt, gnt_viol, rd_hits, gnt_low;
    int drop_pix = -1, stop_at_wr = -1, busy_start_at = -1;
    bit timed_out, busy_at_done, drop_fired, stopped;
    logic [31:0] cur_src, prev_addr;
    logic [31:0] rd_watch = 32'hFFFF_FFFF;

    task automatic start_blit(input logic [31:0] s, input logic [17:0] d);
        @(negedge clk);
        src_base = s;
        dst_off  = d;
        cur_src  = s;
        start    = 1'b1;
        @(negedge clk);
        start    = 1'b0;
        src_base = 32'hDEAD_BEEF;
        dst_off  = 18'h2AAAA;
    endtask

    task automatic run_blit(input int budget);
        bit hit2;
        wr_a.delete(); wr_d.delete();
        t_rd = -1; t_done = -1; done_cnt = 0; gnt_viol = 0; rd_hits = 0; gnt_low = 0;
        drop_fired = 0; stopped = 0; timed_out = 0; busy_at_done = 1; prev_addr = '0;
        for (int c = 0; c < budget; c++) begin
            @(negedge clk);
            if (start) start = 1'b0;
            if (mem_w) begin
                wr_a.push_back(addr_bus);
                wr_d.push_back(data2bus);
            end
            if (!bus_gnt && (mem_w || addr_bus != 0 || data2bus != 0)) gnt_viol++;
            if (!mem_w && addr_bus == rd_watch) rd_hits++;
            if (t_rd < 0 && !mem_w && addr_bus != 0) t_rd = c;
            if (done) begin
                done_cnt++;
                if (t_done < 0) begin
                    t_done = c;
                    busy_at_done = busy;
                end
            end
            if (gnt_low > 0) begin
                gnt_low--;
                if (gnt_low == 0) bus_gnt = 1'b1;
            end
            if (busy_start_at == c) begin
                start = 1'b1;
                src_base = 32'h8000_0000;
                dst_off = 18'h01234;
            end
            if (stop_at_wr >= 0 && wr_a.size() == stop_at_wr) begin
                stopped = 1;
                break;
            end
            if (t_done >= 0 && c >= t_done + 8) break;
            hit2 = drop_pix >= 0 && !drop_fired && !mem_w &&
                   addr_bus == cur_src + 32'(drop_pix) && prev_addr == addr_bus;
            prev_addr = addr_bus;
            if (hit2) begin
                drop_fired = 1;
                @(posedge clk);
                #1 bus_gnt = 1'b0;
                gnt_low = 5;
            end
        end
        if (t_done < 0 && !stopped) timed_out = 1;
    endtask

    task automatic build_exp(input logic [17:0] d, input bit odd);
        logic [17:0] off;
        exp_q.delete(); exp_d.delete();
        for (int k = 0; k < 1024; k++) begin
            if (odd && (k % 2 == 1)) continue;
            off = d + 18'((k / 32) * 512 + (k % 32));
            exp_q.push_back({4'hC, 10'b0, off});
            exp_d.push_back(32'(k));
        end
    endtask

    function automatic int mism();
        int m = 0;
        for (int i = 0; i < exp_q.size() && i < wr_a.size(); i++)
            if (wr_a[i] !== exp_q[i] || wr_d[i] !== exp_d[i]) m++;
        return m;
    endfunction

    task automatic test_reset();
        #1;
        tests++;
        if ({busy, done, bus_req, mem_w, addr_bus, data2bus} !== '0) begin
            fails++; $display("FAIL reset_outputs: got %h required 0", {busy, done, bus_req, mem_w, addr_bus, data2bus});
        end
        repeat (3) @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        tests++;
        if ({busy, done, bus_req, mem_w, addr_bus, data2bus} !== '0) begin
            fails++; $display("FAIL idle_outputs: got %h required 0", {busy, done, bus_req, mem_w, addr_bus, data2bus});
        end
        tests++;
        if (dbg_state !== S_IDLE) begin
            fails++; $display("FAIL idle_state: got %0d required %0d", dbg_state, S_IDLE);
        end
    endtask

    task automatic test_opaque();
        rom_odd = 0;
        build_exp(18'h0, 0);
        start_blit(32'hB000_0000, 18'h0);
        tests++;
        if ({busy, bus_req} !== 2'b11) begin
            fails++; $display("FAIL opaque_busy_req: got %b required 11", {busy, bus_req});
        end
        run_blit(6000);
        tests++;
        if (timed_out !== 0) begin fails++; $display("FAIL opaque_timeout: got %0d required 0", timed_out); end
        tests++;
        if (t_rd !== 0) begin fails++; $display("FAIL opaque_first_rd: got %0d required 0", t_rd); end
        tests++;
        if (wr_a.size() !== 1024) begin fails++; $display("FAIL opaque_writes: got %0d required 1024", wr_a.size()); end
        tests++;
        if (mism() !== 0) begin fails++; $display("FAIL opaque_data: got %0d bad writes required 0", mism()); end
        tests++;
        if (t_done - t_rd !== 4096) begin fails++; $display("FAIL opaque_cycles: got %0d required 4096", t_done - t_rd); end
        tests++;
        if (done_cnt !== 1) begin fails++; $display("FAIL opaque_done_cnt: got %0d required 1", done_cnt); end
        tests++;
        if (busy_at_done !== 0) begin fails++; $display("FAIL opaque_busy_at_done: got %0d required 0", busy_at_done); end
    endtask

    task automatic test_transparency();
        int odd_x;
        rom_odd = 1;
        build_exp(18'h0, 1);
        start_blit(32'hB000_0000, 18'h0);
        run_blit(6000);
        odd_x = 0;
        foreach (wr_a[i]) if (wr_a[i][0]) odd_x++;
        tests++;
        if (wr_a.size() !== 512) begin fails++; $display("FAIL transp_writes: got %0d required 512", wr_a.size()); end
        tests++;
        if (mism() !== 0) begin fails++; $display("FAIL transp_data: got %0d bad writes required 0", mism()); end
        tests++;
        if (odd_x !== 0) begin fails++; $display("FAIL transp_odd_x: got %0d required 0", odd_x); end
        tests++;
        if (t_done - t_rd !== 512 * 4 + 512 * 3) begin
            fails++; $display("FAIL transp_cycles: got %0d required %0d", t_done - t_rd, 512 * 4 + 512 * 3);
        end
        rom_odd = 0;
    endtask

    task automatic test_wrap();
        int bad_nib;
        build_exp(18'h3FFF0, 0);
        start_blit(32'hA000_0000, 18'h3FFF0);
        run_blit(6000);
        bad_nib = 0;
        foreach (wr_a[i]) if (wr_a[i][31:28] != 4'hC) bad_nib++;
        tests++;
        if (wr_a.size() !== 1024) begin fails++; $display("FAIL wrap_writes: got %0d required 1024", wr_a.size()); end
        else begin
            tests++;
            if (wr_a[16] !== 32'hC000_0000) begin fails++; $display("FAIL wrap_x16: got %h required c0000000", wr_a[16]); end
            tests++;
            if (wr_a[15] !== 32'hC003_FFFF) begin fails++; $display("FAIL wrap_x15: got %h required c003ffff", wr_a[15]); end
        end
        tests++;
        if (bad_nib !== 0) begin fails++; $display("FAIL wrap_nibble: got %0d required 0", bad_nib); end
        tests++;
        if (mism() !== 0) begin fails++; $display("FAIL wrap_data: got %0d bad writes required 0", mism()); end
    endtask

    task automatic test_grant_drop();
        int p100;
        build_exp(18'h0, 0);
        drop_pix = 100;
        rd_watch = 32'hB000_0000 + 32'd100;
        start_blit(32'hB000_0000, 18'h0);
        run_blit(6000);
        drop_pix = -1;
        rd_watch = 32'hFFFF_FFFF;
        p100 = 0;
        foreach (wr_a[i]) if (wr_a[i] == 32'hC000_0000 + 32'd3 * 512 + 32'd4) p100++;
        tests++;
        if (drop_fired !== 1) begin fails++; $display("FAIL drop_fired: got %0d required 1", drop_fired); end
        tests++;
        if (gnt_viol !== 0) begin fails++; $display("FAIL drop_bus_quiet: got %0d required 0", gnt_viol); end
        tests++;
        if (rd_hits !== 4) begin fails++; $display("FAIL drop_reread: got %0d required 4", rd_hits); end
        tests++;
        if (p100 !== 1) begin fails++; $display("FAIL drop_single_write: got %0d required 1", p100); end
        tests++;
        if (wr_a.size() !== 1024) begin fails++; $display("FAIL drop_writes: got %0d required 1024", wr_a.size()); end
        tests++;
        if (mism() !== 0) begin fails++; $display("FAIL drop_data: got %0d bad writes required 0", mism()); end
        tests++;
        if (done_cnt !== 1) begin fails++; $display("FAIL drop_done_cnt: got %0d required 1", done_cnt); end
    endtask

    task automatic test_start_while_busy();
        build_exp(18'h00200, 0);
        busy_start_at = 200;
        start_blit(32'hB000_0000, 18'h00200);
        run_blit(6000);
        busy_start_at = -1;
        tests++;
        if (wr_a.size() !== 1024) begin fails++; $display("FAIL busy_start_writes: got %0d required 1024", wr_a.size()); end
        tests++;
        if (mism() !== 0) begin fails++; $display("FAIL busy_start_data: got %0d bad writes required 0", mism()); end
        tests++;
        if (done_cnt !== 1) begin fails++; $display("FAIL busy_start_done_cnt: got %0d required 1", done_cnt); end
    endtask

    task automatic test_reset_abort();
        int act;
        stop_at_wr = 50;
        start_blit(32'hB000_0000, 18'h0);
        run_blit(6000);
        stop_at_wr = -1;
        tests++;
        if (stopped !== 1) begin fails++; $display("FAIL abort_reach_px50: got %0d required 1", stopped); end
        repeat (2) @(posedge clk);
        #2;
        tests++;
        if (addr_bus !== 32'hB000_0032) begin fails++; $display("FAIL abort_rd_px50: got %h required b0000032", addr_bus); end
        rst = 1'b0;
        #1;
        tests++;
        if ({busy, done, bus_req, mem_w, addr_bus, data2bus} !== '0) begin
            fails++; $display("FAIL abort_async_zero: got %h required 0", {busy, done, bus_req, mem_w, addr_bus, data2bus});
        end
        act = 0;
        repeat (4) begin
            @(negedge clk);
            if (busy || done || bus_req || mem_w) act++;
        end
        rst = 1'b1;
        repeat (4) begin
            @(negedge clk);
            if (busy || done || bus_req || mem_w) act++;
        end
        tests++;
        if (act !== 0) begin fails++; $display("FAIL abort_quiet: got %0d active cycles required 0", act); end
        build_exp(18'h00100, 0);
        start_blit(32'hB000_0000, 18'h00100);
        run_blit(6000);
        tests++;
        if (wr_a.size() !== 1024) begin fails++; $display("FAIL restart_writes: got %0d required 1024", wr_a.size()); end
        tests++;
        if (mism() !== 0) begin fails++; $display("FAIL restart_data: got %0d bad writes required 0", mism()); end
        tests++;
        if (done_cnt !== 1) begin fails++; $display("FAIL restart_done_cnt: got %0d required 1", done_cnt); end
    endtask

    initial begin
        test_reset();
        test_opaque();
        test_transparency();
        test_wrap();
        test_grant_drop();
        test_start_while_busy();
        test_reset_abort();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/mio_blit_master.md
# mio_blit_master

Bus-initiator tile blitter for the MIO memory-mapped bus: on a start command it copies one TILE_W×TILE_H tile of 12-bit pixels from a sprite ROM region (0x8xxxxxxx–0xBxxxxxxx) into VRAM (0xCxxxxxxx) and skips transparent pixels. It is the master side of the bus whose slave side is the MIO address decoder. It sits beside the CPU behind an external bus-request/grant mux, and drives the same addr_bus / mem_w / data-out signals the CPU drives. This offloads per-pixel sprite drawing from software.

## Interface
- TILE_W, 32, tile width in pixels
- TILE_H, 32, tile height in pixels (TILE_W*TILE_H ≤ 1024)
- STRIDE, 512, VRAM pixels per screen row
- RD_LAT, 2, cycles from address presentation to valid read data (registered decode + synchronous ROM)
- TRANSP, 12'hF0F, colour key; source pixels equal to it are not written
- clk  in  1  system clock
- rst  in  1  reset: one clock, reset is asynchronous and active-low
- start  in  1  command strobe, sampled only while idle
- src_base  in  32  source ROM base address (region nibble in [31:28], pixel index in [9:0])
- dst_off  in  18  VRAM pixel address of the tile's top-left corner
- busy  out  1  high from the cycle after an accepted start until done
- done  out  1  one-cycle completion pulse
- bus_req  out  1  bus request to the arbiter
- bus_gnt  in  1  bus grant from the arbiter
- addr_bus  out  32  bus address
- mem_w  out  1  bus write strobe
- data2bus  out  32  write data, with the pixel in [11:0] and upper bits 0
- data4bus  in  32  read data, with the pixel in [11:0]

## Operation
- Reset values: all outputs are 0 and the FSM is in IDLE.
- FSM states:
  - IDLE: start=1 → latch src_base and dst_off, clear x, y and idx, go to REQ.
  - REQ: bus_req=1; bus_gnt=1 → RD.
  - RD: drive addr_bus = src_base + idx and mem_w=0 for RD_LAT cycles. On the last cycle, capture pix = data4bus[11:0]. If pix==TRANSP go to NEXT, else go to WR.
  - WR: one cycle with addr_bus = {4'hC, 10'b0, (dst_off + y*STRIDE + x) mod 2^18}, mem_w=1, data2bus={20'b0,pix} → NEXT.
  - NEXT: advance the counters with no bus activity. x wraps at TILE_W and increments y; idx increments. After the last pixel go to DONE, else go to RD.
  - DONE: done=1, busy falls, bus_req falls → IDLE.
- bus_req is held from REQ through NEXT.
- Outside RD and WR, and whenever bus_gnt=0, addr_bus, mem_w and data2bus are 0.
- Source address arithmetic is 32-bit with no region check. Destination address wraps modulo 2^18 and is never carried into the region nibble.
- Grant loss in RD or WR: the bus outputs go to 0 in the same cycle via a combinational gate on bus_gnt. The FSM returns to REQ and the current pixel is retried from RD; no partial write may occur.
- start while busy is ignored.
- Reset mid-operation aborts immediately with no further bus cycles and no done pulse.

## Timing
- start accepted at edge N → busy=1 and bus_req=1 after N.
- With grant already high: first RD cycle at N+2.
- Per opaque pixel: RD_LAT + 1 (WR) + 1 (NEXT) cycles.
- Per transparent pixel: RD_LAT + 1 cycles.
- Full opaque 32×32 tile at RD_LAT=2: 4096 cycles from first RD to DONE.
- done is asserted in the cycle after the last NEXT; busy=0 in that same cycle.
- A new start is accepted the cycle after done.

## Structure
- Shared package mio_pkg holds:
  - the FSM state enum;
  - region nibble constants (VRAM 4'hC, background 4'hB, character 4'hA, ci 4'h9, wall 4'h8);
  - the default TRANSP colour.
- One sub-module: mio_blit_addr_gen, containing the x/y/idx counters, the wrap logic and the destination address computation (y*STRIDE formed by an incrementally added row base, no multiplier).
- The top level holds the FSM and bus gating.

## Test plan
- Opaque tile: src_base=0xB0000000, dst_off=0, ROM pixel=idx[11:0], gnt tied high. Expect 1024 writes; write k goes to 0xC0000000 + (k/32)*512 + k%32 with data k; done arrives 4096 cycles after the first RD.
- Transparency: every odd idx returns 12'hF0F. Expect exactly 512 writes, no write to odd-x addresses, and a total of 512*4 + 512*3 cycles.
- Wrap: dst_off=18'h3FFF0. The row-0 pixel at x=16 writes address 0xC0000000 (wrapped) and the nibble stays C.
- Grant drop: deassert bus_gnt for 5 cycles during a WR of pixel 100. Expect no mem_w in those cycles, pixel 100 re-read and written exactly once, and 1024 total writes.
- start pulsed while busy: no restart, single done. Then rst=0 at pixel 50 → all outputs 0 asynchronously, no done, and a clean restart on the next start.
